// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Registered ALU operand stage (ID/EX boundary). Resolves rs1/rs2 against
//   the register file and up to NUM_FWD forwarding sources, selects ALU
//   operand A (rs1 / pc / zero) and B (rs2 / imm), and captures the result
//   with valid, stall and flush control. No input reaches an output
//   without passing through a register.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, stall, flush    pipeline control
//   rs1_addr/rs2_addr         source register indices
//   rs1_data/rs2_data         register-file read data
//   pc_current, imm           PC and sign-extended immediate
//   ALUSrcA[1:0], ALUSrcB     operand selects
//   fwd_valid/fwd_rd/fwd_data flat per-source forwarding buses, source 0 youngest
//   out_valid, alu_a, alu_b, store_data, fwd_hit_a, fwd_hit_b  registered outputs

// Forward resolution for one source operand. Index 0 has highest priority.
module alu_operand_fwd_sel #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]                        addr_i,
  input  logic [XLEN-1:0]                   rf_data_i,
  input  logic [NUM_FWD-1:0]                fwd_valid_i,
  input  logic [NUM_FWD-1:0][4:0]           fwd_rd_i,
  input  logic [NUM_FWD-1:0][XLEN-1:0]      fwd_data_i,
  output logic [XLEN-1:0]                   data_o,
  output logic                              hit_o
);
  always_comb begin
    data_o = rf_data_i;
    hit_o  = 1'b0;
    // Walk oldest to youngest so the lowest matching index overwrites last.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_rd_i[i] == addr_i) && (addr_i != 5'd0)) begin
        data_o = fwd_data_i[i];
        hit_o  = 1'b1;
      end
    end
    // x0 is hardwired zero; nothing may override it.
    if (addr_i == 5'd0) data_o = '0;
  end
endmodule

module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [4:0]                rs1_addr,
  input  logic [4:0]                rs2_addr,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [XLEN-1:0]           pc_current,
  input  logic [XLEN-1:0]           imm,
  input  logic [1:0]                ALUSrcA,
  input  logic                      ALUSrcB,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [5*NUM_FWD-1:0]      fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0]   fwd_data,
  output logic                      out_valid,
  output logic [XLEN-1:0]           alu_a,
  output logic [XLEN-1:0]           alu_b,
  output logic [XLEN-1:0]           store_data,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b
);
  // Reinterpret flat buses as per-source packed arrays (same bit layout).
  logic [NUM_FWD-1:0][4:0]      fwd_rd_arr;
  logic [NUM_FWD-1:0][XLEN-1:0] fwd_data_arr;
  assign fwd_rd_arr   = fwd_rd;
  assign fwd_data_arr = fwd_data;

  logic [XLEN-1:0] rs1_res, rs2_res;
  logic            rs1_hit, rs2_hit;

  alu_operand_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs1 (
    .addr_i(rs1_addr), .rf_data_i(rs1_data), .fwd_valid_i(fwd_valid),
    .fwd_rd_i(fwd_rd_arr), .fwd_data_i(fwd_data_arr),
    .data_o(rs1_res), .hit_o(rs1_hit)
  );

  alu_operand_fwd_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs2 (
    .addr_i(rs2_addr), .rf_data_i(rs2_data), .fwd_valid_i(fwd_valid),
    .fwd_rd_i(fwd_rd_arr), .fwd_data_i(fwd_data_arr),
    .data_o(rs2_res), .hit_o(rs2_hit)
  );

  logic [XLEN-1:0] alu_a_d, alu_b_d, store_d;
  logic            hit_a_d, hit_b_d;

  always_comb begin
    case (ALUSrcA)
      2'b00:   alu_a_d = rs1_res;
      2'b01:   alu_a_d = pc_current;
      default: alu_a_d = '0;           // 10 zero, 11 reserved -> zero
    endcase
    alu_b_d = ALUSrcB ? imm : rs2_res;
    store_d = rs2_res;
    hit_a_d = (ALUSrcA == 2'b00) && rs1_hit;
    hit_b_d = rs2_hit;                 // store_data consumes rs2 even when B = imm
  end

  logic            valid_q, hit_a_q, hit_b_q;
  logic [XLEN-1:0] alu_a_q, alu_b_q, store_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      store_q <= '0;
      hit_a_q <= 1'b0;
      hit_b_q <= 1'b0;
    end else if (flush || !stall) begin
      // Flush kills the slot; data is loaded anyway since consumers gate on valid.
      valid_q <= flush ? 1'b0 : in_valid;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      store_q <= store_d;
      hit_a_q <= hit_a_d;
      hit_b_q <= hit_b_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign store_data = store_q;
  assign fwd_hit_a  = hit_a_q;
  assign fwd_hit_b  = hit_b_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;
  localparam int XLEN = 32;
  localparam int NF   = 2;

  logic clk = 1'b0;
  logic rst, in_valid, stall, flush, ALUSrcB;
  logic [4:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, pc_current, imm;
  logic [1:0] ALUSrcA;
  logic [NF-1:0] fwd_valid;
  logic [5*NF-1:0] fwd_rd;
  logic [XLEN*NF-1:0] fwd_data;
  logic out_valid, fwd_hit_a, fwd_hit_b;
  logic [XLEN-1:0] alu_a, alu_b, store_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pc_current(pc_current), .imm(imm), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b)
  );

  // Reference model state: expected register contents after each edge.
  logic m_valid, m_ha, m_hb, m_known;
  logic [XLEN-1:0] m_a, m_b, m_sd;

  // Operand resolution straight from the rules: x0 -> 0, first matching source, else RF.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] a, input logic [XLEN-1:0] rf,
                                              output logic hit);
    hit = 1'b0;
    if (a == 5'd0) return '0;
    for (int i = 0; i < NF; i++) begin
      logic [4:0] rd;
      rd = fwd_rd[5*i +: 5];
      if (fwd_valid[i] && rd == a) begin
        hit = 1'b1;
        return fwd_data[XLEN*i +: XLEN];
      end
    end
    return rf;
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic step();
    logic h1, h2;
    logic [XLEN-1:0] r1, r2;
    r1 = resolve(rs1_addr, rs1_data, h1);
    r2 = resolve(rs2_addr, rs2_data, h2);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_ha = 0; m_hb = 0; m_known = 1;
    end else if (flush) begin
      m_valid = 0; m_known = 0;
    end else if (!stall) begin
      m_valid = in_valid;
      m_a  = (ALUSrcA == 2'b00) ? r1 : (ALUSrcA == 2'b01) ? pc_current : '0;
      m_b  = ALUSrcB ? imm : r2;
      m_sd = r2;
      m_ha = (ALUSrcA == 2'b00) && h1;
      m_hb = h2;
      m_known = 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; in_valid = 1; stall = 0; flush = 0;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 20; rs2_data = 7;
    pc_current = 100; imm = 8; ALUSrcA = 2'b00; ALUSrcB = 1'b0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234; imm = 32'h55;
    fwd_valid = 2'b11; fwd_rd = {5'd2, 5'd1}; fwd_data = {32'h11, 32'h22};
    step(); step();
    n_vec++;
    if ({out_valid, fwd_hit_a, fwd_hit_b} !== 3'b000 || alu_a !== 0 || alu_b !== 0 || store_data !== 0) begin
      n_err++;
      $display("FAIL reset: got v=%0b a=%h b=%h sd=%h ha=%0b hb=%0b, need all 0",
               out_valid, alu_a, alu_b, store_data, fwd_hit_a, fwd_hit_b);
    end
    idle_inputs();
    step();
    n_vec++;
    if (out_valid !== 1'b1 || alu_a !== 32'd20) begin
      n_err++;
      $display("FAIL reset_release: got v=%0b a=%0d, need v=1 a=20", out_valid, alu_a);
    end
  endtask

  task automatic test_select();
    logic [XLEN-1:0] exp_a [3] = '{32'd20, 32'd100, 32'd0};
    idle_inputs();
    for (int s = 0; s < 3; s++) begin
      ALUSrcA = 2'(s);
      step();
      n_vec++;
      if (alu_a !== exp_a[s]) begin
        n_err++;
        $display("FAIL select_a%0d: got %0d need %0d", s, alu_a, exp_a[s]);
      end
    end
    ALUSrcA = 2'b11; rs1_data = 32'hFFFF;
    step();
    n_vec++;
    if (alu_a !== 0) begin n_err++; $display("FAIL select_a3: got %0d need 0", alu_a); end
    ALUSrcB = 1'b1;
    step();
    n_vec++;
    if (alu_b !== 32'd8) begin n_err++; $display("FAIL select_b_imm: got %0d need 8", alu_b); end
    ALUSrcB = 1'b0;
    step();
    n_vec++;
    if (alu_b !== 32'd7 || store_data !== 32'd7) begin
      n_err++;
      $display("FAIL select_b_rs2: got b=%0d sd=%0d need 7/7", alu_b, store_data);
    end
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    rs1_addr = 5'd5; rs1_data = 1;
    fwd_rd = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
    fwd_valid = 2'b11;
    step();
    n_vec++;
    if (alu_a !== 32'hAA || fwd_hit_a !== 1'b1) begin
      n_err++; $display("FAIL fwd_both: got a=%h ha=%0b need AA/1", alu_a, fwd_hit_a);
    end
    fwd_valid = 2'b10;
    step();
    n_vec++;
    if (alu_a !== 32'hBB || fwd_hit_a !== 1'b1) begin
      n_err++; $display("FAIL fwd_src1: got a=%h ha=%0b need BB/1", alu_a, fwd_hit_a);
    end
    fwd_valid = 2'b00;
    step();
    n_vec++;
    if (alu_a !== 32'h1 || fwd_hit_a !== 1'b0) begin
      n_err++; $display("FAIL fwd_none: got a=%h ha=%0b need 1/0", alu_a, fwd_hit_a);
    end
    // PC select must not report a forward hit even though rs1 matches.
    fwd_valid = 2'b11; ALUSrcA = 2'b01;
    step();
    n_vec++;
    if (alu_a !== 32'd100 || fwd_hit_a !== 1'b0) begin
      n_err++; $display("FAIL fwd_pc_nohit: got a=%h ha=%0b need 64/0", alu_a, fwd_hit_a);
    end
  endtask

  task automatic test_x0();
    idle_inputs();
    rs2_addr = 5'd0; rs2_data = 32'h1234;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'h0, 32'h55};
    step();
    n_vec++;
    if (alu_b !== 0 || store_data !== 0 || fwd_hit_b !== 1'b0) begin
      n_err++; $display("FAIL x0: got b=%h sd=%h hb=%0b need 0/0/0", alu_b, store_data, fwd_hit_b);
    end
  endtask

  task automatic test_store();
    idle_inputs();
    ALUSrcB = 1'b1; imm = 16; rs2_addr = 5'd3;
    fwd_valid = 2'b10; fwd_rd = {5'd3, 5'd0}; fwd_data = {32'h77, 32'h0};
    step();
    n_vec++;
    if (alu_b !== 32'd16 || store_data !== 32'h77 || fwd_hit_b !== 1'b1) begin
      n_err++; $display("FAIL store: got b=%h sd=%h hb=%0b need 10/77/1", alu_b, store_data, fwd_hit_b);
    end
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    step();
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      rs1_data = $urandom; pc_current = $urandom; in_valid = c[0];
      step();
      n_vec++;
      if (alu_a !== 32'd20 || out_valid !== 1'b1 || alu_b !== 32'd7) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%0b a=%0d b=%0d need 1/20/7", c, out_valid, alu_a, alu_b);
      end
    end
    flush = 1; in_valid = 1;
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_flush: got v=%0b need 0", out_valid); end
    stall = 0; flush = 0; rs1_data = 33; rs2_data = 44;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || alu_a !== 32'd33 || alu_b !== 32'd44) begin
      n_err++; $display("FAIL flush_release: got v=%0b a=%0d b=%0d need 1/33/44", out_valid, alu_a, alu_b);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 29) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      in_valid = $urandom; ALUSrcA = 2'($urandom); ALUSrcB = $urandom;
      rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
      rs1_data = $urandom; rs2_data = $urandom; pc_current = $urandom; imm = $urandom;
      fwd_valid = NF'($urandom);
      for (int i = 0; i < NF; i++) begin
        fwd_rd[5*i +: 5] = 5'($urandom_range(0, 3));
        fwd_data[XLEN*i +: XLEN] = $urandom;
      end
      step();
      n_vec++;
      if (out_valid !== m_valid) begin
        n_err++; $display("FAIL rand%0d valid: got %0b need %0b", c, out_valid, m_valid);
      end
      if (m_known) begin
        n_vec++;
        if (alu_a !== m_a || alu_b !== m_b || store_data !== m_sd || fwd_hit_a !== m_ha || fwd_hit_b !== m_hb) begin
          n_err++;
          $display("FAIL rand%0d data: got a=%h b=%h sd=%h ha=%0b hb=%0b need a=%h b=%h sd=%h ha=%0b hb=%0b",
                   c, alu_a, alu_b, store_data, fwd_hit_a, fwd_hit_b, m_a, m_b, m_sd, m_ha, m_hb);
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_ha = 0; m_hb = 0; m_known = 0;
    test_reset();
    test_select();
    test_fwd_priority();
    test_x0();
    test_store();
    test_stall_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised, registered successor to the ALU operand-A multiplexer. Selects ALU operand A (rs1, PC or zero) and operand B (rs2 or immediate), resolves register-file hazards by forwarding from up to NUM_FWD later pipeline stages, and captures the result in an ID/EX-style pipeline register with valid, stall and flush control. It sits between decode/register-read and the ALU in the pipelined datapath.

## Interface
- XLEN, 32, datapath width in bits
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest stage and has the highest priority
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode slot holds a valid instruction
- stall  in  1  hold the pipeline register contents
- flush  in  1  kill the instruction being captured
- rs1_addr, rs2_addr  in  5 each  source register indices
- rs1_data, rs2_data  in  XLEN each  register-file read data
- pc_current  in  XLEN  PC of the decode-slot instruction
- imm  in  XLEN  sign-extended immediate
- ALUSrcA  in  2  00 = rs1, 01 = pc_current, 10 = zero, 11 = reserved (treated as zero)
- ALUSrcB  in  1  0 = rs2, 1 = imm
- fwd_valid  in  NUM_FWD  per-source "writes a register" flag
- fwd_rd  in  5*NUM_FWD  per-source destination index; source i at bits [5i+4:5i]
- fwd_data  in  XLEN*NUM_FWD  per-source result; source i at bits [XLEN*i+XLEN-1:XLEN*i]
- out_valid  out  1  registered instruction is valid
- alu_a, alu_b  out  XLEN each  registered ALU operands
- store_data  out  XLEN  registered, forwarded rs2 value (for stores, independent of ALUSrcB)
- fwd_hit_a, fwd_hit_b  out  1 each  registered flags: forwarded value used for rs1 / rs2

## Operation
- Resolved rs1:
  - rs1_addr == 0 gives 0, regardless of rs1_data or forwarding.
  - Otherwise, the lowest index i with fwd_valid[i] && fwd_rd[i] == rs1_addr supplies fwd_data[i].
  - Otherwise rs1_data.
- Resolved rs2: same rule.
- Sources with fwd_rd == 0 never match.
- alu_a_next selects by ALUSrcA from resolved rs1, pc_current or 0. alu_b_next = ALUSrcB ? imm : resolved rs2.
- fwd_hit_a is set only when ALUSrcA == 00 and a forward matched. fwd_hit_b is set when a forward matched rs2, whatever ALUSrcB is, because store_data uses it.
- Register update priority per cycle, highest first:
  - rst: all outputs 0.
  - flush: out_valid <= 0; data registers may load but are don't-care.
  - stall: all registers hold.
  - otherwise: load all next values; out_valid <= in_valid.
- When in_valid = 0 and there is no stall or flush, data registers still load. Consumers must qualify with out_valid.
- No arithmetic on data; widths pass through unchanged.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and are stable for cycle N+1.
- Reset: out_valid, alu_a, alu_b, store_data, fwd_hit_a and fwd_hit_b are all 0 after the first edge with rst = 1. rst mid-stall or mid-flush still clears everything.
- Stall: outputs are held for as many cycles as stall stays high. The upstream stage must hold its inputs; this block does not buffer them. Forwarded values are re-resolved from current inputs on the first non-stalled edge.
- flush and stall high together: flush wins, so out_valid = 0 after the edge.
- Multiple forward matches: lowest index wins. Only the selected source's data reaches the outputs.
- Forwarding is purely combinational from the fwd_* inputs into the register. There is no combinational path from any input to any output.

## Test plan
- Reset: drive rst = 1 for 2 cycles with nonzero inputs -> all outputs 0; release -> first valid capture one cycle later.
- Basic select, with rs1_data = 20, pc_current = 100, imm = 8, no forwarding:
  - ALUSrcA = 00 -> alu_a = 20.
  - ALUSrcA = 01 -> alu_a = 100.
  - ALUSrcA = 10 -> alu_a = 0.
  - ALUSrcB = 1 -> alu_b = 8.
  - ALUSrcB = 0 with rs2_data = 7 -> alu_b = 7 and store_data = 7.
- Forward priority, with rs1_addr = 5, rs1_data = 1, fwd 0 = (valid, rd 5, 0xAA), fwd 1 = (valid, rd 5, 0xBB):
  - Both valid -> alu_a = 0xAA, fwd_hit_a = 1.
  - fwd_valid[0] = 0 -> alu_a = 0xBB.
  - Both invalid -> alu_a = 1, fwd_hit_a = 0.
- x0 rule: rs2_addr = 0, rs2_data = 0x1234, fwd 0 = (valid, rd 0, 0x55), ALUSrcB = 0 -> alu_b = 0, store_data = 0, fwd_hit_b = 0.
- Store path: ALUSrcB = 1, imm = 16, rs2_addr = 3, fwd 1 = (valid, rd 3, 0x77) -> alu_b = 16, store_data = 0x77, fwd_hit_b = 1.
- Stall and flush:
  - Capture alu_a = 20, then hold stall = 1 for 3 cycles while changing inputs -> outputs unchanged.
  - Assert stall and flush together -> out_valid = 0.
  - Release both with in_valid = 1 -> out_valid = 1 with the new operands.
